// File: rtl/ahb_sram_ctrl_pkg.sv
// Shared AHB-lite encodings and controller state codes for the SRAM subordinate.
package ahb_sram_ctrl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StWdata  = 3'd1;
  localparam state_t StRstall = 3'd2;
  localparam state_t StErr1   = 3'd3;
  localparam state_t StErr2   = 3'd4;

endpackage

// File: rtl/ahb_sram_ctrl_if.sv
// AHB-lite bus bundle between a manager/interconnect and the SRAM subordinate.
interface ahb_sram_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  hsel;
  logic [31:0]           haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic                  hready;
  logic [DATA_WIDTH-1:0] hwdata;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hreadyout;
  logic                  hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hready, hwdata,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hready, hwdata,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ahb_ben_decode.sv
// Maps an AHB transfer size and low address bits to 32-bit byte-lane enables.
module ahb_ben_decode
  import ahb_sram_ctrl_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lsb,
  output logic [3:0] ben,
  output logic       misaligned
);

  // Sizes above a word yield no lanes; the caller rejects them separately.
  always_comb begin
    ben        = 4'b0000;
    misaligned = 1'b0;
    case (hsize)
      HSIZE_BYTE: ben = 4'b0001 << addr_lsb;
      HSIZE_HALF: begin
        ben        = 4'b0011 << addr_lsb;
        misaligned = addr_lsb[0];
      end
      HSIZE_WORD: begin
        ben        = 4'b1111;
        misaligned = |addr_lsb;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-lite subordinate driving a single-port byte-enabled SRAM with a registered read port.
module ahb_sram_ctrl
  import ahb_sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 10,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned BYTES         = DATA_WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  ahb_sram_ctrl_if.slave           bus,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [BYTES-1:0]         mem_ben,
  output logic                     mem_wren,
  input  logic [DATA_WIDTH-1:0]    mem_q
);

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]               ben_q, ben_d;

  logic [ADDRESS_WIDTH-1:0] haddr_word;
  logic [3:0]               dec_ben;
  logic                     misaligned;
  logic                     in_range;
  logic                     accept;
  logic                     legal;

  ahb_ben_decode u_ben_decode (
    .hsize      (bus.hsize),
    .addr_lsb   (bus.haddr[1:0]),
    .ben        (dec_ben),
    .misaligned (misaligned)
  );

  assign haddr_word = bus.haddr[ADDRESS_WIDTH+1:2];
  assign in_range   = (bus.haddr >> (ADDRESS_WIDTH + 2)) == 32'd0;
  assign accept     = bus.hsel && ((bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ));
  assign legal      = (bus.hsize <= HSIZE_WORD) && !misaligned && in_range;

  // RSTALL and ERR1 drive hreadyout low, so they advance without waiting on hready.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ben_d   = ben_q;
    case (state_q)
      StRstall: state_d = StIdle;
      StErr1:   state_d = StErr2;
      default: begin
        if (bus.hready) begin
          if (!accept) begin
            state_d = StIdle;
          end else if (!legal) begin
            state_d = StErr1;
          end else if (bus.hwrite) begin
            state_d = StWdata;
            addr_d  = haddr_word;
            ben_d   = dec_ben;
          end else if (state_q == StWdata) begin
            // SRAM port is busy with the write; replay the read address next cycle.
            state_d = StRstall;
            addr_d  = haddr_word;
          end else begin
            state_d = StIdle;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      ben_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ben_q   <= ben_d;
    end
  end

  always_comb begin
    bus.hreadyout = !((state_q == StRstall) || (state_q == StErr1));
    bus.hresp     = ((state_q == StErr1) || (state_q == StErr2)) ? HRESP_ERROR : HRESP_OKAY;
    bus.hrdata    = mem_q;
    mem_wren      = (state_q == StWdata);
    mem_ben       = mem_wren ? ben_q : '0;
    mem_wdata     = bus.hwdata;
    mem_addr      = ((state_q == StWdata) || (state_q == StRstall)) ? addr_q : haddr_word;
  end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Scoreboard bench for ahb_sram_ctrl with a behavioural registered-read SRAM.
module tb_ahb_sram_ctrl;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    logic        resp;
    int          waits;
    logic [3:0]  ben;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_ben;
  logic        mem_wren;
  logic [31:0] mem_q;

  ahb_sram_ctrl_if bus ();
  assign bus.hready = bus.hreadyout;

  ahb_sram_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ben   (mem_ben),
    .mem_wren  (mem_wren),
    .mem_q     (mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:1023] = '{default: 32'h0};
  int          wren_cnt = 0;

  always @(posedge clk) begin
    if (mem_wren) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_ben[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
    mem_q <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (mem_wren) wren_cnt <= wren_cnt + 1;
  end

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] next_wd = 32'h0;
  logic        dp_active = 1'b0;
  int          dp_waits = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one address phase and holds it until the bus accepts it; hwdata carries the
  // previous transfer's write data, as in the AHB pipeline.
  task automatic issue(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wd,
                       input logic e_rd, input logic [31:0] e_data, input logic e_resp,
                       input int e_waits, input logic [3:0] e_ben);
    int   cyc;
    logic rdy;
    exp_t e;
    cyc           = 0;
    bus.hsel      = sel;
    bus.htrans    = trans;
    bus.hwrite    = wr;
    bus.haddr     = addr;
    bus.hsize     = size;
    bus.hwdata    = next_wd;
    if (sel && trans[1]) begin
      e.rd    = e_rd;
      e.data  = e_data;
      e.resp  = e_resp;
      e.waits = e_waits;
      e.ben   = e_ben;
      exp_q.push_back(e);
    end
    forever begin
      @(negedge clk);
      rdy = bus.hreadyout;
      @(posedge clk);
      #1;
      if (rdy) break;
      cyc++;
      if (cyc > 20) begin
        check("addr_phase_timeout", 32'(cyc), 32'd0);
        break;
      end
    end
    next_wd = wd;
  endtask

  task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                    input logic [3:0] ben, input logic err);
    issue(1'b1, 2'b10, 1'b1, a, sz, d, 1'b0, 32'h0, err, err ? 1 : 0, ben);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input int waits);
    issue(1'b1, 2'b10, 1'b0, a, 3'd2, 32'h0, 1'b1, d, 1'b0, waits, 4'h0);
  endtask

  task automatic idle();
    issue(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0, 0, 4'h0);
  endtask

  initial begin
    int          c0;
    exp_t        e;
    rst        = 1'b1;
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
    bus.hwrite = 1'b0;
    bus.haddr  = 32'h0;
    bus.hsize  = 3'd0;
    bus.hwdata = 32'h0;
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (rst) begin
            exp_q.delete();
            dp_active = 1'b0;
            dp_waits  = 0;
          end else begin
            if (!mem_wren) check("ben_idle_zero", 32'(mem_ben), 32'h0);
            if (dp_active) begin
              if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
              end else if (!bus.hreadyout) begin
                check("hresp_wait", 32'(bus.hresp), 32'(exp_q[0].resp));
                dp_waits++;
              end else begin
                e = exp_q.pop_front();
                check("hresp", 32'(bus.hresp), 32'(e.resp));
                check("wait_states", 32'(dp_waits), 32'(e.waits));
                if (e.rd && !e.resp) check("hrdata", bus.hrdata, e.data);
                if (!e.rd && !e.resp) begin
                  check("mem_wren", 32'(mem_wren), 32'd1);
                  check("mem_ben", 32'(mem_ben), 32'(e.ben));
                end
                dp_waits = 0;
              end
            end
            if (bus.hreadyout) dp_active = bus.hsel && bus.htrans[1];
          end
        end
      end
      begin : stimulus
        repeat (3) @(posedge clk);
        #1;
        check("rst_hreadyout", 32'(bus.hreadyout), 32'd1);
        check("rst_hresp", 32'(bus.hresp), 32'd0);
        check("rst_wren", 32'(mem_wren), 32'd0);
        check("rst_ben", 32'(mem_ben), 32'd0);
        rst = 1'b0;

        // Reset in the middle of a write data phase must cancel the write.
        wr(32'h100, 3'd2, 32'hCAFEF00D, 4'hF, 1'b0);
        bus.hsel   = 1'b0;
        bus.htrans = 2'b00;
        bus.hwdata = 32'hCAFEF00D;
        #1;
        check("wren_before_rst", 32'(mem_wren), 32'd1);
        rst = 1'b1;
        #1;
        check("wren_in_rst", 32'(mem_wren), 32'd0);
        check("ben_in_rst", 32'(mem_ben), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        next_wd = 32'h0;
        #1;
        check("post_rst_hreadyout", 32'(bus.hreadyout), 32'd1);
        check("post_rst_hresp", 32'(bus.hresp), 32'd0);
        rd(32'h100, 32'h0, 0);

        // Word write then read-after-write of the same location.
        wr(32'h010, 3'd2, 32'hDEADBEEF, 4'hF, 1'b0);
        rd(32'h010, 32'hDEADBEEF, 1);
        idle();

        // Sub-word writes on their byte lanes, merged word read.
        wr(32'h020, 3'd0, 32'h0000_0011, 4'b0001, 1'b0);
        wr(32'h021, 3'd0, 32'h0000_2200, 4'b0010, 1'b0);
        wr(32'h022, 3'd1, 32'h4433_0000, 4'b1100, 1'b0);
        rd(32'h020, 32'h44332211, 1);
        idle();

        // Back-to-back writes then back-to-back reads.
        for (int i = 0; i < 4; i++) wr(32'h40 + 32'(4 * i), 3'd2, 32'hA5A5_0000 + 32'(i), 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) rd(32'h40 + 32'(4 * i), 32'hA5A5_0000 + 32'(i), (i == 0) ? 1 : 0);
        idle();
        idle();

        // Illegal transfers: misaligned word, oversize, out of window.
        c0 = wren_cnt;
        wr(32'h002, 3'd2, 32'h1111_1111, 4'h0, 1'b1);
        wr(32'h000, 3'd3, 32'h2222_2222, 4'h0, 1'b1);
        wr(32'h1000, 3'd2, 32'h3333_3333, 4'h0, 1'b1);
        idle();
        idle();
        idle();
        check("err_no_write", 32'(wren_cnt), 32'(c0));
        rd(32'h000, 32'h0, 0);
        idle();

        // BUSY and deselected writes are ignored with an OKAY response.
        c0 = wren_cnt;
        issue(1'b1, 2'b01, 1'b1, 32'h80, 3'd2, 32'h5555_5555, 1'b0, 32'h0, 1'b0, 0, 4'h0);
        check("busy_hreadyout", 32'(bus.hreadyout), 32'd1);
        check("busy_hresp", 32'(bus.hresp), 32'd0);
        issue(1'b0, 2'b10, 1'b1, 32'h80, 3'd2, 32'h6666_6666, 1'b0, 32'h0, 1'b0, 0, 4'h0);
        check("unsel_hreadyout", 32'(bus.hreadyout), 32'd1);
        check("unsel_hresp", 32'(bus.hresp), 32'd0);
        idle();
        check("busy_no_write", 32'(wren_cnt), 32'(c0));
        rd(32'h080, 32'h0, 0);
        idle();
        idle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
